instr_loader: RTL and testbench

Boot-time program loader for the EnDMe processor: the writer side of the instruction ROM that instruction fetch reads. It accepts a byte stream over a valid/ready handshake, assembles 9-bit instructions, and writes them sequentially into instruction memory starting at address 0. It holds the core in reset until the image is complete, then releases it.

---
 rtl/instr_loader.sv | 185 ++++++++++++++++++
 tb/tb_instr_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot-time loader: assembles 9-bit instructions from a byte stream and writes them to instruction memory.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module instr_loader (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [8:0]  wr_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_INS_LO,
        S_INS_HI,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] index_q, index_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  low_q, low_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [8:0]  wr_data_q, wr_data_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        load_done_q, load_done_d;
    logic        load_err_q, load_err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
`endif

    logic        accept;
    logic [15:0] index_inc;

    always_comb begin
        in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                   (state_q == S_INS_LO) || (state_q == S_INS_HI)
`ifdef LOADER_CHECKSUM_EN
                   || (state_q == S_CHK)
`endif
                   ;
    end

    assign accept    = in_valid && in_ready;
    assign index_inc = index_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        len_d       = len_q;
        low_d       = low_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d       = accept ? (xor_q ^ in_data) : xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // Release the core only once DONE has been visible for a cycle.
                if (state_q == S_DONE) cpu_hold_d = 1'b0;
                if (start) begin
                    state_d     = S_LEN_LO;
                    index_d     = 16'd0;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                    cpu_hold_d  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    xor_d       = 8'd0;
`endif
                end
            end
            S_LEN_LO: if (accept) begin
                len_d[7:0] = in_data;
                state_d    = S_LEN_HI;
            end
            S_LEN_HI: if (accept) begin
                len_d[15:8] = in_data;
                if ({in_data, len_q[7:0]} != 16'd0) begin
                    state_d = S_INS_LO;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d     = S_DONE;
                    load_done_d = 1'b1;
`endif
                end
            end
            S_INS_LO: if (accept) begin
                low_d   = in_data;
                state_d = S_INS_HI;
            end
            S_INS_HI: if (accept) begin
                if (in_data[7:1] != 7'd0) begin
                    state_d    = S_ERR;
                    load_err_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = index_q;
                    wr_data_d = {in_data[0], low_q};
                    index_d   = index_inc;
                    if (index_inc == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d     = S_DONE;
                        load_done_d = 1'b1;
`endif
                    end else begin
                        state_d = S_INS_LO;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: if (accept) begin
                if (in_data == xor_q) begin
                    state_d     = S_DONE;
                    load_done_d = 1'b1;
                end else begin
                    state_d    = S_ERR;
                    load_err_d = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            index_q     <= 16'd0;
            len_q       <= 16'd0;
            low_q       <= 8'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 16'd0;
            wr_data_q   <= 9'd0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            len_q       <= len_d;
            low_q       <= low_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader; the checksum scenario runs when LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [8:0]  wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int errors = 0;
    int checks = 0;
    bit bp = 1'b0;
    logic [15:0] log_addr[$];
    logic [8:0]  log_data[$];

    instr_loader dut (
        .CLK(CLK), .RESET(RESET), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            $display("write addr=%0d data=%03h", wr_addr, wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge CLK);
        if (bp) repeat ($urandom_range(0, 3)) @(negedge CLK);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge CLK);
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Sends the checksum byte only in checksum builds, leaving the sample point one cycle after it.
    task automatic send_chk(input logic [7:0] cs);
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs);
        @(negedge CLK);
`endif
    endtask

    initial begin
        int n0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_err", {31'd0, load_err}, 32'd0);
        check("rst_addr", {16'd0, wr_addr}, 32'd0);
        RESET = 1'b0;

        // Basic two-instruction image
        pulse_start();
        check("start_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'hA5); send_byte(8'h01);
        @(negedge CLK);
        check("b0_wr_en", {31'd0, wr_en}, 32'd1);
        check("b0_addr", {16'd0, wr_addr}, 32'd0);
        check("b0_data", {23'd0, wr_data}, 32'h1A5);
        send_byte(8'h3C); send_byte(8'h00);
        @(negedge CLK);
        check("b1_wr_en", {31'd0, wr_en}, 32'd1);
        check("b1_addr", {16'd0, wr_addr}, 32'd1);
        check("b1_data", {23'd0, wr_data}, 32'h03C);
        send_chk(8'h9A);
        check("b_done", {31'd0, load_done}, 32'd1);
        check("b_hold_still", {31'd0, cpu_hold}, 32'd1);
        @(negedge CLK);
        check("b_hold_rel", {31'd0, cpu_hold}, 32'd0);
        check("b_wr_en_low", {31'd0, wr_en}, 32'd0);
        check("b_ready_low", {31'd0, in_ready}, 32'd0);

        // Malformed INS_HI, then an empty image recovers
        pulse_start();
        check("m_hold", {31'd0, cpu_hold}, 32'd1);
        n0 = log_addr.size();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h12); send_byte(8'h02);
        @(negedge CLK);
        check("m_err", {31'd0, load_err}, 32'd1);
        check("m_done", {31'd0, load_done}, 32'd0);
        check("m_hold_err", {31'd0, cpu_hold}, 32'd1);
        check("m_ready", {31'd0, in_ready}, 32'd0);
        @(negedge CLK);
        check("m_nowrite", log_addr.size() - n0, 32'd0);
        check("m_hold_late", {31'd0, cpu_hold}, 32'd1);
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        @(negedge CLK);
        send_chk(8'h00);
        check("z_done", {31'd0, load_done}, 32'd1);
        check("z_err", {31'd0, load_err}, 32'd0);
        @(negedge CLK);
        check("z_hold", {31'd0, cpu_hold}, 32'd0);

        // Back-pressure and ignored mid-load start
        bp = 1'b1;
        pulse_start();
        n0 = log_addr.size();
        send_byte(8'h03); send_byte(8'h00);
        pulse_start();
        check("bp_ready_after_start", {31'd0, in_ready}, 32'd1);
        send_byte(8'h11); send_byte(8'h01); send_byte(8'h22);
        pulse_start();
        send_byte(8'h00); send_byte(8'h33); send_byte(8'h01);
        @(negedge CLK);
        send_chk(8'h03);
        bp = 1'b0;
        check("bp_done", {31'd0, load_done}, 32'd1);
        repeat (3) @(negedge CLK);
        check("bp_count", log_addr.size() - n0, 32'd3);
        if (log_addr.size() >= n0 + 3) begin
            check("bp_a0", {16'd0, log_addr[n0]}, 32'd0);
            check("bp_d0", {23'd0, log_data[n0]}, 32'h111);
            check("bp_a1", {16'd0, log_addr[n0+1]}, 32'd1);
            check("bp_d1", {23'd0, log_data[n0+1]}, 32'h022);
            check("bp_a2", {16'd0, log_addr[n0+2]}, 32'd2);
            check("bp_d2", {23'd0, log_data[n0+2]}, 32'h133);
        end

        // Reset mid-load
        pulse_start();
        n0 = log_addr.size();
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h44); send_byte(8'h00);
        send_byte(8'h55);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check("r_hold", {31'd0, cpu_hold}, 32'd1);
        check("r_ready", {31'd0, in_ready}, 32'd0);
        check("r_wr_en", {31'd0, wr_en}, 32'd0);
        check("r_addr", {16'd0, wr_addr}, 32'd0);
        check("r_data", {23'd0, wr_data}, 32'd0);
        check("r_done", {31'd0, load_done}, 32'd0);
        check("r_err", {31'd0, load_err}, 32'd0);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("r_count", log_addr.size() - n0, 32'd1);
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h77); send_byte(8'h01);
        @(negedge CLK);
        check("r2_wr_en", {31'd0, wr_en}, 32'd1);
        check("r2_addr", {16'd0, wr_addr}, 32'd0);
        check("r2_data", {23'd0, wr_data}, 32'h177);
        send_chk(8'h77);
        check("r2_done", {31'd0, load_done}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hA5); send_byte(8'h01);
        send_byte(8'hA5);
        @(negedge CLK);
        check("c_done", {31'd0, load_done}, 32'd1);
        check("c_err", {31'd0, load_err}, 32'd0);
        pulse_start();
        n0 = log_addr.size();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hA5); send_byte(8'h01);
        send_byte(8'hA4);
        @(negedge CLK);
        check("cx_err", {31'd0, load_err}, 32'd1);
        check("cx_done", {31'd0, load_done}, 32'd0);
        check("cx_count", log_addr.size() - n0, 32'd1);
        if (log_addr.size() > n0) begin
            check("cx_addr", {16'd0, log_addr[n0]}, 32'd0);
            check("cx_data", {23'd0, log_data[n0]}, 32'h1A5);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
